fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1 bit, hazard stall: hold PC and the IF/ID register.
REQ-005 SHALL have port flush, input, 1 bit, squash the IF/ID register to a bubble.
REQ-006 SHALL have port branch_taken, input, 1 bit, branch resolved as taken this cycle.
REQ-007 SHALL have port branch_target, input, 32 bits, branch destination byte address.
REQ-008 SHALL have port jump, input, 1 bit, unconditional jump this cycle.
REQ-009 SHALL have port jump_target, input, 32 bits, jump destination byte address.
REQ-010 SHALL have port imem_addr, output, 32 bits, byte address to instruction memory.
REQ-011 SHALL have port imem_instr, input, 32 bits, instruction word returned combinationally by memory.
REQ-012 SHALL have port ifid_instr, output, 32 bits, registered instruction for decode.
REQ-013 SHALL have port ifid_pc4, output, 32 bits, registered PC+4 of that instruction.
REQ-014 SHALL have port ifid_valid, output, 1 bit, ifid_instr holds a real fetched instruction.
REQ-015 SHALL have port fetch_count, output, 16 bits, count of instructions accepted into IF/ID.

Function
REQ-016 SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally, with zero added latency.
REQ-017 SHALL select next PC, highest priority first: jump -> jump_target; branch_taken -> branch_target; stall -> PC unchanged; else PC+4.
REQ-018 SHALL let a redirect (jump or branch_taken) override stall for the PC.
REQ-019 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-020 SHALL pass targets through unmodified; alignment is the producer's responsibility.
REQ-021 SHALL, each edge with no stall, flush or redirect, load ifid_instr<=imem_instr, ifid_pc4<=PC+4, ifid_valid<=1.
REQ-022 SHALL, on flush or redirect, load ifid_instr<=0, ifid_pc4<=0, ifid_valid<=0; this overrides stall.
REQ-023 SHALL, on stall with no flush or redirect, hold all IF/ID outputs unchanged.
REQ-024 SHALL increment fetch_count only on edges that perform REQ-021, saturating at 16'hFFFF.
REQ-025 SHALL deliver one fetched instruction to decode one cycle after its address appears on imem_addr.

Reset
REQ-026 SHALL, on an edge with reset=1, set PC=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0; reset overrides all other inputs.
REQ-027 SHALL, mid-operation reset, discard any pending redirect or stall; the first post-reset fetch is at RESET_PC.
REQ-028 SHALL, on the first edge after reset deasserts with no other input active, latch the word at RESET_PC with ifid_pc4=RESET_PC+4.

Verification
REQ-029 SHALL check sequential fetch: reset, then 3 free cycles -> imem_addr 0,4,8,12; ifid_pc4 4,8,12; fetch_count=3.
REQ-030 SHALL check stall: stall=1 for 2 cycles at PC=8 -> imem_addr stays 8; IF/ID holds pc4=8; fetch_count unchanged.
REQ-031 SHALL check branch: branch_taken=1, branch_target=32'h20 at PC=12 -> next imem_addr=32'h20; ifid_valid=0 for one cycle.
REQ-032 SHALL check priority: jump=1 (target 32'h30) with branch_taken=1 and stall=1 -> imem_addr=32'h30; bubble in IF/ID.
REQ-033 SHALL check wrap and saturation: PC=32'hFFFF_FFFC free cycle -> imem_addr=0; with fetch_count=16'hFFFF, one more fetch leaves it 16'hFFFF.
REQ-034 SHALL check reset mid-stall: stall=1 and reset=1 at PC=32'h24 -> PC=RESET_PC, ifid_valid=0, fetch_count=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register with redirect/stall selection and the IF/ID
// pipeline register feeding decode, plus a saturating count of accepted fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [15:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        squash;
  logic        accept;

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign redirect  = jump | branch_taken;
  assign squash    = flush | redirect;
  assign accept    = !squash && !stall;

  // Redirects win over stall; flush alone does not touch the PC.
  always_comb begin
    next_pc = pc4;
    if (jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
    else if (stall)        next_pc = pc;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (reset || squash) begin
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (accept) begin
      ifid_instr <= imem_instr;
      ifid_pc4   <= pc4;
      ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             fetch_count <= 16'd0;
    else if (accept && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: per-cycle vectors push expected state into a
// scoreboard queue that is popped and compared after each rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_instr, ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: each word is the bitwise inverse of its address.
  assign imem_instr = ~imem_addr;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic        rst, stl, fl, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_vld;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic rst, logic stl, logic fl, logic br, logic [31:0] bt,
                              logic jp, logic [31:0] jt, logic [31:0] a, logic [31:0] ins,
                              logic [31:0] p4, logic v, logic [15:0] c);
    vec_t r;
    r.rst = rst; r.stl = stl; r.fl = fl; r.br = br; r.bt = bt; r.jp = jp; r.jt = jt;
    r.e_addr = a; r.e_instr = ins; r.e_pc4 = p4; r.e_vld = v; r.e_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; flush = v.fl; branch_taken = v.br;
    branch_target = v.bt; jump = v.jp; jump_target = v.jt;
  endtask

  task automatic compare_head(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: vector %0d had no expectation", idx);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d_imem_addr", idx), imem_addr, e.e_addr);
    chk($sformatf("v%0d_ifid_instr", idx), ifid_instr, e.e_instr);
    chk($sformatf("v%0d_ifid_pc4", idx), ifid_pc4, e.e_pc4);
    chk($sformatf("v%0d_ifid_valid", idx), {31'd0, ifid_valid}, {31'd0, e.e_vld});
    chk($sformatf("v%0d_fetch_count", idx), {16'd0, fetch_count}, {16'd0, e.e_cnt});
  endtask

  task automatic free_cycle();
    reset = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 32'd0; jump_target = 32'd0;
    @(posedge clk);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 32'd0; jump_target = 32'd0;

    //            rst stl fl br bt            jp jt            addr          instr         pc4           v  cnt
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'hFFFFFFFF, 32'h4,        1, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'hFFFFFFFB, 32'h8,        1, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'hFFFFFFF7, 32'hC,        1, 16'd3));
    vecs.push_back(mk(0, 0, 0, 1, 32'h20,       0, 32'h0,        32'h20,       32'h0,        32'h0,        0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h24,       32'hFFFFFFDF, 32'h24,       1, 16'd4));
    vecs.push_back(mk(0, 1, 0, 1, 32'h40,       1, 32'h30,       32'h30,       32'h0,        32'h0,        0, 16'd4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h4,        32'h4,        32'h0,        32'h0,        0, 16'd4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'hFFFFFFFB, 32'h8,        1, 16'd5));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'hFFFFFFFB, 32'h8,        1, 16'd5));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'hFFFFFFFB, 32'h8,        1, 16'd5));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'hFFFFFFF7, 32'hC,        1, 16'd6));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h0,        32'h0,        0, 16'd6));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h0,        32'h0,        0, 16'd6));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h24,       32'h24,       32'h0,        32'h0,        0, 16'd6));
    vecs.push_back(mk(1, 1, 0, 1, 32'h80,       0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'hFFFFFFFF, 32'h4,        1, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h00000003, 32'h0,        1, 16'd2));
    vecs.push_back(mk(0, 1, 0, 1, 32'h100,      0, 32'h0,        32'h100,      32'h0,        32'h0,        0, 16'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      compare_head(i);
    end

    // Saturation: 65533 more fetches bring the count from 2 to 16'hFFFF.
    @(negedge clk);
    for (int i = 0; i < 65533; i++) free_cycle();
    #1;
    chk("sat_reached", {16'd0, fetch_count}, 32'h0000FFFF);
    chk("sat_pc", imem_addr, 32'h000400F4);
    @(negedge clk);
    free_cycle();
    #1;
    chk("sat_hold", {16'd0, fetch_count}, 32'h0000FFFF);
    chk("sat_valid", {31'd0, ifid_valid}, 32'd1);
    chk("sat_pc4", ifid_pc4, 32'h000400F8);
    chk("sat_instr", ifid_instr, ~32'h000400F4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
